// File: rtl/sysbus_mem_ctrl.sv
// SysBus memory responder: latches address/write data from SysBus and runs wait-stated
// read/write cycles on an external asynchronous SRAM, reporting completion with Ready/Done.
module sysbus_mem_ctrl #(
    parameter int unsigned WaitStates = 1,
    parameter int unsigned AddrBits   = 12
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [15:0]         i_sys_bus,
    input  logic                i_addr_we,
    input  logic                i_read_req,
    input  logic                i_write_req,
    output logic [15:0]         o_data_out,
    output logic                o_ready,
    output logic                o_done,
    output logic                o_addr_err,
    output logic [AddrBits-1:0] o_ram_addr,
    output logic [15:0]         o_ram_wdata,
    input  logic [15:0]         i_ram_rdata,
    output logic                o_ram_cs_n,
    output logic                o_ram_oe_n,
    output logic                o_ram_we_n
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] WAIT_INIT = 4'(WaitStates);

    logic [1:0]          r_state;
    logic [15:0]         r_addr;
    logic [15:0]         r_wdata;
    logic [15:0]         r_data_out;
    logic [AddrBits-1:0] r_ram_addr;
    logic [3:0]          r_wait;
    logic                r_is_write;
    logic                r_err;

    logic                w_idle;
    logic                w_accept;
    logic [15:0]         w_addr_next;
    logic                w_out_of_range;
    logic                w_access;

    // An AddrWe on the accepting edge must be seen by both the range check and RamAddr.
    always_comb begin
        w_idle         = (r_state == ST_IDLE);
        w_accept       = w_idle && (i_read_req || i_write_req);
        w_addr_next    = (w_idle && i_addr_we) ? i_sys_bus : r_addr;
        w_out_of_range = (w_addr_next >> AddrBits) != 16'd0;
        w_access       = ((r_state == ST_SETUP) || (r_state == ST_STROBE)) && !r_err;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= 16'd0;
            r_wdata    <= 16'd0;
            r_data_out <= 16'd0;
            r_ram_addr <= '0;
            r_wait     <= 4'd0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_addr_we) begin
                        r_addr <= i_sys_bus;
                    end
                    if (w_accept) begin
                        r_state    <= ST_SETUP;
                        r_is_write <= i_write_req;
                        r_err      <= w_out_of_range;
                        r_ram_addr <= w_addr_next[AddrBits-1:0];
                        if (i_write_req) begin
                            r_wdata <= i_sys_bus;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_wait  <= WAIT_INIT;
                end
                ST_STROBE: begin
                    if (r_wait == 4'd0) begin
                        r_state <= ST_DONE;
                        if (!r_is_write) begin
                            r_data_out <= r_err ? 16'h0000 : i_ram_rdata;
                        end
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data_out  = r_data_out;
    assign o_ready     = w_idle;
    assign o_done      = (r_state == ST_DONE);
    assign o_addr_err  = (r_state == ST_DONE) && r_err;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_wdata;
    assign o_ram_cs_n  = !w_access;
    assign o_ram_oe_n  = !(w_access && (r_state == ST_STROBE) && !r_is_write);
    assign o_ram_we_n  = !(w_access && (r_state == ST_STROBE) && r_is_write);

endmodule

// File: tb/tb_sysbus_mem_ctrl.sv
// Bench for sysbus_mem_ctrl: three instances (WaitStates 1, 0, 3) on behavioural SRAMs,
// table vectors, randomized transactions against a word-level memory model, corner sequences.
module tb_sysbus_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus      [3];
    logic        addr_we  [3];
    logic        rd_req   [3];
    logic        wr_req   [3];
    logic [15:0] data_out [3];
    logic        ready    [3];
    logic        done     [3];
    logic        addr_err [3];
    logic [11:0] ram_addr [3];
    logic [15:0] ram_wdata[3];
    logic [15:0] ram_rdata[3];
    logic        cs_n     [3];
    logic        oe_n     [3];
    logic        we_n     [3];

    int checks = 0;
    int errors = 0;

    function automatic int ws_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        sysbus_mem_ctrl #(
            .WaitStates(WS),
            .AddrBits  (12)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_sys_bus  (bus[g]),
            .i_addr_we  (addr_we[g]),
            .i_read_req (rd_req[g]),
            .i_write_req(wr_req[g]),
            .o_data_out (data_out[g]),
            .o_ready    (ready[g]),
            .o_done     (done[g]),
            .o_addr_err (addr_err[g]),
            .o_ram_addr (ram_addr[g]),
            .o_ram_wdata(ram_wdata[g]),
            .i_ram_rdata(ram_rdata[g]),
            .o_ram_cs_n (cs_n[g]),
            .o_ram_oe_n (oe_n[g]),
            .o_ram_we_n (we_n[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAMs, cleared on the first edge (which falls inside reset).
    logic [15:0] sram [3][4096];
    bit          sram_ready = 1'b0;
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int g = 0; g < 3; g++)
                for (int a = 0; a < 4096; a++) sram[g][a] <= 16'h0000;
            sram_ready <= 1'b1;
        end else begin
            for (int g = 0; g < 3; g++)
                if (!cs_n[g] && !we_n[g]) sram[g][ram_addr[g]] <= ram_wdata[g];
        end
    end
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++)
            ram_rdata[g] <= (!cs_n[g] && !oe_n[g]) ? sram[g][ram_addr[g]] : 16'hDEAD;
    end

    // Transaction-level model of instance 0: word memory plus last read result.
    logic [15:0] model_mem [int];
    logic [15:0] model_dout = 16'h0000;
    logic [15:0] cur_addr   = 16'h0000;

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0000;
    endfunction

    task automatic model_apply(input logic [15:0] a, input bit wr, input bit rd,
                               input logic [15:0] wd);
        bit oor;
        oor = a >= 16'h1000;
        if (wr) begin
            if (!oor) model_mem[int'(a)] = wd;
        end else if (rd) begin
            model_dout = oor ? 16'h0000 : model_rd(a);
        end
        cur_addr = a;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode 0: reuse latched Addr, 1: AddrWe on a prior cycle, 2: AddrWe on the accept edge.
    task automatic do_txn(input int g, input int mode, input logic [15:0] addr,
                          input bit wr, input bit rd, input logic [15:0] wdata,
                          output int done_cyc, output bit err, output logic [15:0] dout,
                          output int cs_lo, output int oe_lo, output int we_lo,
                          output int rdy_hi, output bit rdy_after);
        if (mode == 1) begin
            addr_we[g] = 1'b1;
            bus[g]     = addr;
            @(posedge clk);
            @(negedge clk);
            addr_we[g] = 1'b0;
        end
        addr_we[g] = (mode == 2);
        bus[g]     = (mode == 2) ? addr : wdata;
        wr_req[g]  = wr;
        rd_req[g]  = rd;
        @(posedge clk);
        @(negedge clk);
        addr_we[g] = 1'b0;
        wr_req[g]  = 1'b0;
        rd_req[g]  = 1'b0;
        bus[g]     = 16'($urandom_range(0, 65535));
        done_cyc = -1; err = 1'b0; dout = 16'h0;
        cs_lo = 0; oe_lo = 0; we_lo = 0; rdy_hi = 0; rdy_after = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (!cs_n[g]) cs_lo++;
            if (!oe_n[g]) oe_lo++;
            if (!we_n[g]) we_lo++;
            if (ready[g]) rdy_hi++;
            if (done[g]) begin
                done_cyc = k;
                err      = addr_err[g];
                dout     = data_out[g];
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (done_cyc > 0) begin
            @(posedge clk);
            @(negedge clk);
            rdy_after = ready[g];
        end
    endtask

    task automatic run_check(input int g, input int mode, input logic [15:0] addr,
                             input bit wr, input bit rd, input logic [15:0] wdata,
                             input bit exp_err, input logic [15:0] exp_dout, input string tag);
        int          dc, cl, ol, wl, rh, ws;
        bit          e, ra;
        logic [15:0] d;
        ws = ws_of(g);
        do_txn(g, mode, addr, wr, rd, wdata, dc, e, d, cl, ol, wl, rh, ra);
        chk({tag, " done_cycle"}, dc, ws + 3);
        chk({tag, " addr_err"}, 32'(e), 32'(exp_err));
        chk({tag, " data_out"}, 32'(d), 32'(exp_dout));
        chk({tag, " cs_low_cycles"}, cl, exp_err ? 0 : ws + 2);
        chk({tag, " oe_low_cycles"}, ol, (rd && !wr && !exp_err) ? ws + 1 : 0);
        chk({tag, " we_low_cycles"}, wl, (wr && !exp_err) ? ws + 1 : 0);
        chk({tag, " ready_during"}, rh, 0);
        chk({tag, " ready_after"}, 32'(ra), 32'd1);
    endtask

    typedef struct {
        int          mode;
        logic [15:0] addr;
        bit          wr;
        bit          rd;
        logic [15:0] wdata;
        bit          exp_err;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pos [$];
        vecs[0]  = '{1, 16'h0123, 1'b1, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
        vecs[1]  = '{1, 16'h0123, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hBEEF};
        vecs[2]  = '{1, 16'h1000, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[3]  = '{1, 16'h0FFF, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000};
        vecs[4]  = '{1, 16'h0FFF, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h1234};
        vecs[5]  = '{1, 16'h0000, 1'b1, 1'b0, 16'hA5A5, 1'b0, 16'h1234};
        vecs[6]  = '{1, 16'h8000, 1'b1, 1'b0, 16'h5555, 1'b1, 16'h1234};
        vecs[7]  = '{1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hA5A5};
        vecs[8]  = '{1, 16'h0123, 1'b1, 1'b1, 16'hCAFE, 1'b0, 16'hA5A5};
        vecs[9]  = '{0, 16'h0123, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hCAFE};
        vecs[10] = '{2, 16'h0005, 1'b1, 1'b0, 16'h0005, 1'b0, 16'hCAFE};
        vecs[11] = '{1, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0005};

        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            bus[g] = 16'h0; addr_we[g] = 1'b0; rd_req[g] = 1'b0; wr_req[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset ready", 32'(ready[0]), 32'd1);
        chk("reset done", 32'(done[0]), 32'd0);
        chk("reset addr_err", 32'(addr_err[0]), 32'd0);
        chk("reset data_out", 32'(data_out[0]), 32'd0);
        chk("reset cs_n", 32'(cs_n[0]), 32'd1);
        chk("reset oe_n", 32'(oe_n[0]), 32'd1);
        chk("reset we_n", 32'(we_n[0]), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_check(0, vecs[i].mode, vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata,
                      vecs[i].exp_err, vecs[i].exp_dout, $sformatf("vec%0d", i));
            model_apply(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
        end

        for (int i = 0; i < 40; i++) begin
            int          mode, op, r;
            logic [15:0] a, wd;
            bit          wr, rd, oor;
            logic [15:0] exp_d;
            mode = $urandom_range(0, 2);
            op   = $urandom_range(0, 2);
            r    = $urandom_range(0, 9);
            wr   = (op != 1);
            rd   = (op != 0);
            if (mode == 0) a = cur_addr;
            else if (r == 0) a = 16'(16'h1000 + $urandom_range(0, 16'hEFFF));
            else if (r < 5) a = 16'($urandom_range(0, 7));
            else a = 16'(16'h0FF8 + $urandom_range(0, 7));
            wd    = (mode == 2) ? a : 16'($urandom_range(0, 65535));
            oor   = a >= 16'h1000;
            exp_d = (rd && !wr) ? (oor ? 16'h0000 : model_rd(a)) : model_dout;
            run_check(0, mode, a, wr, rd, wd, oor, exp_d, $sformatf("rand%0d", i));
            model_apply(a, wr, rd, wd);
        end

        // Requests and AddrWe arriving mid-transaction must be dropped.
        run_check(0, 1, 16'h0010, 1'b1, 1'b0, 16'h1111, 1'b0, model_dout, "pre 010");
        run_check(0, 1, 16'h0020, 1'b1, 1'b0, 16'h2222, 1'b0, model_dout, "pre 020");
        addr_we[0] = 1'b1; bus[0] = 16'h0010;
        @(posedge clk); @(negedge clk);
        addr_we[0] = 1'b0; rd_req[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        rd_req[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        addr_we[0] = 1'b1; bus[0] = 16'h0020; rd_req[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        addr_we[0] = 1'b0; rd_req[0] = 1'b0;
        chk("ignore ram_addr", 32'(ram_addr[0]), 32'h010);
        @(posedge clk); @(negedge clk);
        chk("ignore done", 32'(done[0]), 32'd1);
        chk("ignore data_out", 32'(data_out[0]), 32'h1111);
        @(posedge clk); @(negedge clk);
        chk("ignore no requeue", 32'(ready[0]), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("ignore no requeue done", 32'(done[0]), 32'd0);
        run_check(0, 0, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h1111, "addr kept");

        // ReadReq held high: each new accept lands on the IDLE cycle right after DONE.
        addr_we[0] = 1'b1; bus[0] = 16'h0020;
        @(posedge clk); @(negedge clk);
        addr_we[0] = 1'b0; rd_req[0] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 25) rd_req[0] = 1'b0;
            if (done[0]) begin
                pos.push_back(k);
                chk($sformatf("b2b data_out@%0d", k), 32'(data_out[0]), 32'h2222);
            end
            @(posedge clk);
        end
        @(negedge clk);
        chk("b2b done count", pos.size(), 5);
        for (int i = 0; i < pos.size(); i++)
            chk($sformatf("b2b done%0d cycle", i), pos[i], 4 + 5 * i);

        run_check(1, 1, 16'h0055, 1'b1, 1'b0, 16'h3C3C, 1'b0, 16'h0000, "ws0 wr");
        run_check(1, 1, 16'h0055, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h3C3C, "ws0 rd");
        run_check(1, 1, 16'hF000, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, "ws0 oor rd");
        run_check(2, 1, 16'h00AA, 1'b1, 1'b0, 16'h9696, 1'b0, 16'h0000, "ws3 wr");
        run_check(2, 1, 16'h00AA, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h9696, "ws3 rd");
        run_check(2, 1, 16'h2000, 1'b1, 1'b0, 16'h7777, 1'b1, 16'h9696, "ws3 oor wr");
        run_check(2, 1, 16'h00AA, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h9696, "ws3 rd again");

        // Reset in the middle of a write strobe.
        addr_we[0] = 1'b1; bus[0] = 16'h0030;
        @(posedge clk); @(negedge clk);
        addr_we[0] = 1'b0; bus[0] = 16'h7777; wr_req[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        wr_req[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst pre we_n", 32'(we_n[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst we_n", 32'(we_n[0]), 32'd1);
        chk("rst cs_n", 32'(cs_n[0]), 32'd1);
        chk("rst data_out", 32'(data_out[0]), 32'd0);
        chk("rst ready", 32'(ready[0]), 32'd1);
        chk("rst done", 32'(done[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int nd;
            nd = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (done[0]) nd++;
            end
            chk("rst no done", nd, 0);
        end
        run_check(0, 1, 16'h0030, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, "rst aborted wr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
